// File: rtl/wb_gpio_timer_pkg.sv
// Shared constants for the Wishbone GPIO + timer block: pad width,
// register offsets, CTRL bit positions and the byte-lane mask helper.
package wb_gpio_timer_pkg;

  localparam int IO_W   = 38;
  localparam int HI_W   = IO_W - 32;
  localparam int CTRL_W = 3;

  localparam logic [7:0] OFF_OUT_LO = 8'h00;
  localparam logic [7:0] OFF_OUT_HI = 8'h04;
  localparam logic [7:0] OFF_OEB_LO = 8'h08;
  localparam logic [7:0] OFF_OEB_HI = 8'h0C;
  localparam logic [7:0] OFF_IN_LO  = 8'h10;
  localparam logic [7:0] OFF_IN_HI  = 8'h14;
  localparam logic [7:0] OFF_CTRL   = 8'h18;
  localparam logic [7:0] OFF_LOAD   = 8'h1C;
  localparam logic [7:0] OFF_VAL    = 8'h20;
  localparam logic [7:0] OFF_STAT   = 8'h24;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_timer_cnt.sv
// Down-counting timer: LOAD/VAL/CTRL/EXPIRED state, one-shot or periodic
// reload, and the registered interrupt output.
module wb_gpio_timer_cnt
  import wb_gpio_timer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ctrl_wr_i,
  input  logic [CTRL_W-1:0] ctrl_wdata_i,
  input  logic              load_wr_i,
  input  logic [31:0]       load_wdata_i,
  input  logic              stat_w1c_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       load_o,
  output logic [31:0]       val_o,
  output logic              expired_o,
  output logic              irq_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       val_q, val_d;
  logic              expired_q, expired_d;
  logic              irq_q, irq_d;
  logic              expire_s;

  // Next-state for the timer: bus writes, countdown, expiry and reload.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    val_d     = val_q;
    expired_d = expired_q;
    expire_s  = ctrl_q[CTRL_EN] & (val_q == 32'd0);

    if (load_wr_i) begin
      load_d = load_wdata_i;
    end else begin
      load_d = load_q;
    end

    // A LOAD write always restarts VAL, even mid-count or at expiry.
    if (load_wr_i) begin
      val_d = load_wdata_i;
    end else if (ctrl_q[CTRL_EN]) begin
      if (val_q != 32'd0) begin
        val_d = val_q - 32'd1;
      end else if (ctrl_q[CTRL_RELOAD]) begin
        val_d = load_q;
      end else begin
        val_d = 32'd0;
      end
    end else begin
      val_d = val_q;
    end

    // A bus CTRL write overrides the one-shot hardware EN clear.
    if (ctrl_wr_i) begin
      ctrl_d = ctrl_wdata_i;
    end else if (expire_s & ~ctrl_q[CTRL_RELOAD]) begin
      ctrl_d          = ctrl_q;
      ctrl_d[CTRL_EN] = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end

    // Expiry wins over a simultaneous write-1-to-clear.
    if (expire_s) begin
      expired_d = 1'b1;
    end else if (stat_w1c_i) begin
      expired_d = 1'b0;
    end else begin
      expired_d = expired_q;
    end

    irq_d = expired_d & ctrl_d[CTRL_IRQ_EN];
  end

  // Timer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= {CTRL_W{1'b0}};
      load_q    <= 32'd0;
      val_q     <= 32'd0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      val_q     <= val_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign load_o    = load_q;
  assign val_o     = val_q;
  assign expired_o = expired_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/wb_gpio_timer.sv
// Wishbone slave exposing 38 GPIO pads (out/oeb/in) and a down-counting
// timer with interrupt. Single-cycle registered ack, 256-byte window.
module wb_gpio_timer
  import wb_gpio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic            irq_o
);

  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     out_lo_q, out_lo_d, oeb_lo_q, oeb_lo_d;
  logic [HI_W-1:0] out_hi_q, out_hi_d, oeb_hi_q, oeb_hi_d;
  logic [IO_W-1:0] sync1_q, sync2_q;

  logic            hit_s, acc_s, wr_s;
  logic [7:0]      off_s;
  logic [31:0]     mask_s, rdata_s;

  logic [CTRL_W-1:0] ctrl_s, ctrl_wdata_s;
  logic [31:0]       load_s, load_wdata_s, val_s;
  logic              expired_s, ctrl_wr_s, load_wr_s, stat_w1c_s;

  // A hit is only accepted while no ack is outstanding, so a held strobe
  // is acknowledged every second cycle.
  assign hit_s  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc_s  = hit_s & ~ack_q;
  assign wr_s   = acc_s & wbs_we_i;
  assign off_s  = wbs_adr_i[7:0];
  assign mask_s = sel_mask(wbs_sel_i);

  assign ctrl_wr_s    = wr_s & (off_s == OFF_CTRL);
  assign ctrl_wdata_s = (ctrl_s & ~mask_s[CTRL_W-1:0]) | (wbs_dat_i[CTRL_W-1:0] & mask_s[CTRL_W-1:0]);
  assign load_wr_s    = wr_s & (off_s == OFF_LOAD);
  assign load_wdata_s = (load_s & ~mask_s) | (wbs_dat_i & mask_s);
  assign stat_w1c_s   = wr_s & (off_s == OFF_STAT) & wbs_sel_i[0] & wbs_dat_i[0];

  wb_gpio_timer_cnt u_cnt (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .ctrl_wr_i    (ctrl_wr_s),
    .ctrl_wdata_i (ctrl_wdata_s),
    .load_wr_i    (load_wr_s),
    .load_wdata_i (load_wdata_s),
    .stat_w1c_i   (stat_w1c_s),
    .ctrl_o       (ctrl_s),
    .load_o       (load_s),
    .val_o        (val_s),
    .expired_o    (expired_s),
    .irq_o        (irq_o)
  );

  // Read mux; unmapped offsets and bits above a register's width read 0.
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_OUT_LO: rdata_s = out_lo_q;
      OFF_OUT_HI: rdata_s = {{(32-HI_W){1'b0}}, out_hi_q};
      OFF_OEB_LO: rdata_s = oeb_lo_q;
      OFF_OEB_HI: rdata_s = {{(32-HI_W){1'b0}}, oeb_hi_q};
      OFF_IN_LO:  rdata_s = sync2_q[31:0];
      OFF_IN_HI:  rdata_s = {{(32-HI_W){1'b0}}, sync2_q[IO_W-1:32]};
      OFF_CTRL:   rdata_s = {{(32-CTRL_W){1'b0}}, ctrl_s};
      OFF_LOAD:   rdata_s = load_s;
      OFF_VAL:    rdata_s = val_s;
      OFF_STAT:   rdata_s = {31'd0, expired_s};
      default:    rdata_s = 32'd0;
    endcase
  end

  // Next-state for the bus response and the GPIO output/enable registers.
  always_comb begin
    ack_d    = acc_s;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    oeb_lo_d = oeb_lo_q;
    oeb_hi_d = oeb_hi_q;

    if (acc_s & ~wbs_we_i) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'd0;
    end

    if (wr_s) begin
      case (off_s)
        OFF_OUT_LO: out_lo_d = (out_lo_q & ~mask_s) | (wbs_dat_i & mask_s);
        OFF_OUT_HI: out_hi_d = (out_hi_q & ~mask_s[HI_W-1:0]) | (wbs_dat_i[HI_W-1:0] & mask_s[HI_W-1:0]);
        OFF_OEB_LO: oeb_lo_d = (oeb_lo_q & ~mask_s) | (wbs_dat_i & mask_s);
        OFF_OEB_HI: oeb_hi_d = (oeb_hi_q & ~mask_s[HI_W-1:0]) | (wbs_dat_i[HI_W-1:0] & mask_s[HI_W-1:0]);
        default: begin
          out_lo_d = out_lo_q;
          out_hi_d = out_hi_q;
          oeb_lo_d = oeb_lo_q;
          oeb_hi_d = oeb_hi_q;
        end
      endcase
    end else begin
      out_lo_d = out_lo_q;
      out_hi_d = out_hi_q;
      oeb_lo_d = oeb_lo_q;
      oeb_hi_d = oeb_hi_q;
    end
  end

  // Bus response, GPIO registers and the two-flop pad input synchronizer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      out_lo_q <= 32'd0;
      out_hi_q <= {HI_W{1'b0}};
      oeb_lo_q <= 32'hFFFF_FFFF;
      oeb_hi_q <= {HI_W{1'b1}};
      sync1_q  <= {IO_W{1'b0}};
      sync2_q  <= {IO_W{1'b0}};
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      oeb_lo_q <= oeb_lo_d;
      oeb_hi_q <= oeb_hi_d;
      sync1_q  <= io_in;
      sync2_q  <= sync1_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = {out_hi_q, out_lo_q};
  assign io_oeb    = {oeb_hi_q, oeb_lo_q};

endmodule

// File: tb/tb_wb_gpio_timer.sv
// Directed testbench for wb_gpio_timer: GPIO writes, window decode,
// synchronizer latency, back-to-back acks, periodic and one-shot timer,
// and asynchronous reset mid-count.
module tb_wb_gpio_timer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [37:0] io_in, io_out, io_oeb;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wb_gpio_timer #(.BASE_ADR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus read; returns at #1 after the ack edge, or after 16 cycles without ack.
  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit acked);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
    d = 32'd0; acked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!acked) begin
        @(posedge clk); #1;
        if (ack) begin
          d = rdat;
          acked = 1'b1;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Bus write; a missing ack within 16 cycles is counted as a failure.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acked;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; adr = a; wdat = d;
    acked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!acked) begin
        @(posedge clk); #1;
        if (ack) acked = 1'b1;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (acked !== 1'b1) begin
      errors++;
      $display("FAIL wb_write_ack adr=%h got_ack=%0d expected=1", a, acked);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; bit k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack, rdat, io_out, irq} !== {1'b0, 32'd0, 38'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%h io_out=%h irq=%b expected all 0", ack, rdat, io_out, irq);
    end
    checks++;
    if (io_oeb !== 38'h3F_FFFF_FFFF) begin
      errors++;
      $display("FAIL reset_oeb got=%h expected=3fffffffff", io_oeb);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 32'h08, d, k);
    checks++;
    if ({k, d} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL reset_oeb_lo_read ack=%b got=%h expected=ffffffff", k, d);
    end
  endtask

  task automatic test_gpio_write();
    logic [31:0] d; bit k;
    wb_write(BASE + 32'h00, 32'hA5A5_A5A5, 4'b0011);
    checks++;
    if (io_out[31:0] !== 32'h0000_A5A5) begin
      errors++;
      $display("FAIL out_lo_sel got=%h expected=0000a5a5", io_out[31:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_one_cycle got=%b expected=0", ack);
    end
    wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h04, d, k);
    checks++;
    if ({d, io_out[37:32]} !== {32'h0000_003F, 6'h3F}) begin
      errors++;
      $display("FAIL out_hi_width got=%h pads=%h expected=0000003f/3f", d, io_out[37:32]);
    end
    wb_write(BASE + 32'h0C, 32'h0000_00C0, 4'b0001);
    checks++;
    if (io_oeb !== {6'h00, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL oeb_hi_write got=%h expected=00ffffffff", io_oeb);
    end
  endtask

  task automatic test_window();
    logic [31:0] d; bit k;
    wb_read(BASE + 32'h100, d, k);
    checks++;
    if (k !== 1'b0) begin
      errors++;
      $display("FAIL out_of_window_ack got=%b expected=0", k);
    end
    wb_read(BASE + 32'h3C, d, k);
    checks++;
    if ({k, d} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL unmapped_read ack=%b got=%h expected ack=1 data=0", k, d);
    end
    wb_write(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'h00, d, k);
    checks++;
    if (d !== 32'h0000_A5A5) begin
      errors++;
      $display("FAIL unmapped_write_ignored got=%h expected=0000a5a5", d);
    end
  endtask

  task automatic test_sync();
    logic [31:0] d; bit k;
    @(posedge clk); #1;
    io_in = 38'd0;
    io_in[37] = 1'b1;
    wb_read(BASE + 32'h14, d, k);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL sync_too_early got=%h expected=0", d);
    end
    repeat (2) @(posedge clk);
    #1;
    wb_read(BASE + 32'h14, d, k);
    checks++;
    if (d !== 32'h0000_0020) begin
      errors++;
      $display("FAIL sync_in_hi got=%h expected=00000020", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (pat !== 4'b0101) begin
      errors++;
      $display("FAIL back_to_back_ack got=%b expected=0101", pat);
    end
  endtask

  task automatic test_timer_periodic();
    wb_write(BASE + 32'h1C, 32'd3, 4'hF);
    wb_write(BASE + 32'h18, 32'h7, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq !== (i == 4)) begin
        errors++;
        $display("FAIL periodic_first cycle=%0d irq=%b expected=%b", i, irq, (i == 4));
      end
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h24; wdat = 32'd1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear irq=%b expected=0", irq);
    end
    for (int i = 6; i <= 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (irq !== (i == 8)) begin
        errors++;
        $display("FAIL periodic_repeat cycle=%0d irq=%b expected=%b", i, irq, (i == 8));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE + 32'h24; wdat = 32'd1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if ({ack, irq} !== 2'b11) begin
      errors++;
      $display("FAIL w1c_vs_expiry ack=%b irq=%b expected ack=1 irq=1", ack, irq);
    end
    wb_write(BASE + 32'h18, 32'h0, 4'hF);
    wb_write(BASE + 32'h24, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL timer_stop irq=%b expected=0", irq);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] v, c, s; bit k;
    wb_write(BASE + 32'h1C, 32'd5, 4'hF);
    wb_write(BASE + 32'h18, 32'h1, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    wb_read(BASE + 32'h20, v, k);
    wb_read(BASE + 32'h18, c, k);
    wb_read(BASE + 32'h24, s, k);
    checks++;
    if ({v, c, s, irq} !== {32'd0, 32'd0, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL one_shot val=%h ctrl=%h stat=%h irq=%b expected 0/0/1/0", v, c, s, irq);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v, c; bit k;
    wb_write(BASE + 32'h1C, 32'd100, 4'hF);
    wb_write(BASE + 32'h18, 32'h5, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h20;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, rdat, io_out, irq} !== {1'b0, 32'd0, 38'd0, 1'b0}) begin
      errors++;
      $display("FAIL midcount_reset ack=%b dat=%h io_out=%h irq=%b expected all 0", ack, rdat, io_out, irq);
    end
    checks++;
    if (io_oeb !== 38'h3F_FFFF_FFFF) begin
      errors++;
      $display("FAIL midcount_reset_oeb got=%h expected=3fffffffff", io_oeb);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL dropped_access_ack got=%b expected=0", ack);
    end
    wb_read(BASE + 32'h20, v, k);
    wb_read(BASE + 32'h18, c, k);
    checks++;
    if ({v, c} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_timer val=%h ctrl=%h expected 0/0", v, c);
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; wdat = 32'd0; io_in = 38'd0;
    test_reset();
    test_gpio_write();
    test_window();
    test_sync();
    test_back_to_back();
    test_timer_periodic();
    test_one_shot();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
